// File: rtl/tcam_pkg.sv
// tcam_pkg: shared TCAM widths, segment status codes and reader FSM states
package tcam_pkg;
  localparam int TCAM_DATA_BITS = 10;
  localparam int TCAM_FRAGMENTS = 5;
  localparam int TCAM_FRAG_BITS = 3;
  localparam int TCAM_IDWID = 2;
  localparam int TCAM_MASKWID = TCAM_FRAGMENTS;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] SINGLE = 2'b01;
  localparam logic [1:0] COLLIDED = 2'b11;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;
endpackage

// File: rtl/segment_compare.sv
// segment_compare: masked per-fragment key equality for one TCAM segment
module segment_compare #(
  parameter int DATA_BITS = 10,
  parameter int FRAGMENTS = 5,
  parameter int MASKWID = FRAGMENTS
) (
  input  logic                 valid,
  input  logic [MASKWID-1:0]   mask,
  input  logic [DATA_BITS-1:0] seg_key,
  input  logic [DATA_BITS-1:0] search_key,
  output logic                 hit
);
  localparam int FRAG_WID = DATA_BITS / FRAGMENTS;
  logic [FRAGMENTS-1:0] frag_ok;
  for (genvar g = 0; g < FRAGMENTS; g++) begin : g_frag
    assign frag_ok[g] = mask[g] || seg_key[g*FRAG_WID +: FRAG_WID] == search_key[g*FRAG_WID +: FRAG_WID];
  end
  assign hit = valid && &frag_ok;
endmodule

// File: rtl/status_reader.sv
// status_reader: walks every key fragment through SDRAM, resolving the highest-priority matching rule
module status_reader
  import tcam_pkg::*;
#(
  parameter int DATA_BITS = TCAM_DATA_BITS,
  parameter int FRAGMENTS = TCAM_FRAGMENTS,
  parameter int FRAG_BITS = TCAM_FRAG_BITS,
  parameter int IDWID = TCAM_IDWID,
  parameter int MASKWID = FRAGMENTS,
  localparam int FRAG_WID = DATA_BITS / FRAGMENTS,
  localparam int ADDR_WID = FRAG_BITS + FRAG_WID,
  localparam int PRIOWID = IDWID,
  localparam int SEGWID = 2 + IDWID + MASKWID + DATA_BITS + PRIOWID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_search,
  input  logic [DATA_BITS-1:0] i_search_key,
  output logic                 o_busy,
  output logic                 o_sdram_read,
  output logic [ADDR_WID-1:0]  o_sdram_addr,
  input  logic                 i_sdram_readvalid,
  input  logic [SEGWID-1:0]    i_sdram_readdata,
  output logic                 o_search_done,
  output logic                 o_match,
  output logic [IDWID-1:0]     o_match_id,
  output logic [PRIOWID-1:0]   o_match_priority,
  output logic                 o_collision,
  output logic                 o_timeout
);
  state_t state, nxt;
  logic [DATA_BITS-1:0] key_q;
  logic [FRAG_BITS-1:0] f;
  logic [3:0] tcnt;
  logic [SEGWID-1:0] seg_q;
  logic win_v, coll;
  logic [IDWID-1:0] win_id;
  logic [PRIOWID-1:0] win_pr;
  logic [1:0] seg_status;
  logic [IDWID-1:0] seg_id;
  logic [MASKWID-1:0] seg_mask;
  logic [DATA_BITS-1:0] seg_key;
  logic [PRIOWID-1:0] seg_pr;
  logic seg_valid, hit, take, last, tmo;
  logic win_v_n, coll_n;
  logic [IDWID-1:0] win_id_n;
  logic [PRIOWID-1:0] win_pr_n;
  assign seg_status = seg_q[SEGWID-1 -: 2];
  assign seg_id = seg_q[PRIOWID+DATA_BITS+MASKWID +: IDWID];
  assign seg_mask = seg_q[PRIOWID+DATA_BITS +: MASKWID];
  assign seg_key = seg_q[PRIOWID +: DATA_BITS];
  assign seg_pr = seg_q[PRIOWID-1:0];
  assign seg_valid = seg_status == SINGLE || seg_status == COLLIDED;
  segment_compare #(.DATA_BITS(DATA_BITS), .FRAGMENTS(FRAGMENTS), .MASKWID(MASKWID)) u_cmp (
    .valid(seg_valid),
    .mask(seg_mask),
    .seg_key(seg_key),
    .search_key(key_q),
    .hit(hit)
  );
  // Strictly-greater replacement keeps the earliest fragment on priority ties
  assign take = state == EVAL && hit && (!win_v || seg_pr > win_pr);
  assign win_v_n = win_v || take;
  assign win_id_n = take ? seg_id : win_id;
  assign win_pr_n = take ? seg_pr : win_pr;
  assign coll_n = coll || (state == EVAL && seg_status == COLLIDED);
  assign last = f == FRAG_BITS'(FRAGMENTS - 1);
  assign tmo = state == WAIT && !i_sdram_readvalid && tcnt == 4'd14;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:  nxt = i_search ? ISSUE : IDLE;
      ISSUE: nxt = WAIT;
      WAIT:  nxt = i_sdram_readvalid ? EVAL : tmo ? DONE : WAIT;
      EVAL:  nxt = last ? DONE : ISSUE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered, so the read strobe lands in the first WAIT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      key_q <= '0;
      f <= '0;
      tcnt <= '0;
      seg_q <= '0;
      win_v <= 1'b0;
      win_id <= '0;
      win_pr <= '0;
      coll <= 1'b0;
      o_busy <= 1'b0;
      o_sdram_read <= 1'b0;
      o_sdram_addr <= '0;
      o_search_done <= 1'b0;
      o_match <= 1'b0;
      o_match_id <= '0;
      o_match_priority <= '0;
      o_collision <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state <= nxt;
      o_busy <= nxt != IDLE;
      o_sdram_read <= state == ISSUE;
      o_search_done <= nxt == DONE;
      if (state == IDLE && i_search) begin
        key_q <= i_search_key;
        f <= '0;
        win_v <= 1'b0;
        win_id <= '0;
        win_pr <= '0;
        coll <= 1'b0;
      end
      if (state == ISSUE) begin
        o_sdram_addr <= {f, key_q[f*FRAG_WID +: FRAG_WID]};
        tcnt <= '0;
      end
      if (state == WAIT) begin
        tcnt <= tcnt + 4'd1;
        if (i_sdram_readvalid) seg_q <= i_sdram_readdata;
      end
      if (state == EVAL) begin
        win_v <= win_v_n;
        win_id <= win_id_n;
        win_pr <= win_pr_n;
        coll <= coll_n;
        if (!last) f <= f + 1'b1;
      end
      if (nxt == DONE) begin
        o_match <= win_v_n && !tmo;
        o_match_id <= tmo ? '0 : win_id_n;
        o_match_priority <= tmo ? '0 : win_pr_n;
        o_collision <= coll_n;
        o_timeout <= tmo;
      end
    end
  end
endmodule

// File: tb/tb_status_reader.sv
// tb_status_reader: table-driven searches against a latency-configurable SDRAM model, plus reset/busy sequences
module tb_status_reader;
  import tcam_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic i_search;
  logic [9:0] i_search_key;
  logic o_busy, o_sdram_read, i_sdram_readvalid, o_search_done;
  logic [4:0] o_sdram_addr;
  logic [20:0] i_sdram_readdata;
  logic o_match, o_collision, o_timeout;
  logic [1:0] o_match_id, o_match_priority;
  int total = 0, passed = 0;
  logic [4:0][20:0] mem;
  logic [9:0] cur_key;
  int lat_l, hold_frag, rd_idx, m_idx;

  typedef struct {
    logic [9:0] key;
    logic [4:0][20:0] segs;
    int l;
    int hold;
    int lat;
    logic m;
    logic [1:0] id;
    logic [1:0] pr;
    logic c;
    logic t;
  } vec_t;
  vec_t vt[14];

  status_reader dut (
    .clk(clk), .reset(reset), .i_search(i_search), .i_search_key(i_search_key),
    .o_busy(o_busy), .o_sdram_read(o_sdram_read), .o_sdram_addr(o_sdram_addr),
    .i_sdram_readvalid(i_sdram_readvalid), .i_sdram_readdata(i_sdram_readdata),
    .o_search_done(o_search_done), .o_match(o_match), .o_match_id(o_match_id),
    .o_match_priority(o_match_priority), .o_collision(o_collision), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [20:0] seg(input logic [1:0] st, input logic [1:0] id, input logic [4:0] mask,
                                      input logic [9:0] k, input logic [1:0] pr);
    return {st, id, mask, k, pr};
  endfunction

  function automatic vec_t mk(input logic [9:0] k, input int l, input int h, input int lat, input logic m,
                              input logic [1:0] id, input logic [1:0] pr, input logic c, input logic t);
    vec_t v;
    v.key = k; v.segs = '0; v.l = l; v.hold = h; v.lat = lat;
    v.m = m; v.id = id; v.pr = pr; v.c = c; v.t = t;
    return v;
  endfunction

  // SDRAM model: answers each strobe L cycles later unless that fragment is withheld
  initial begin
    i_sdram_readvalid = 1'b0;
    i_sdram_readdata = '0;
    forever begin
      @(negedge clk);
      if (o_sdram_read) begin
        m_idx = rd_idx;
        chk("addr", 32'(o_sdram_addr), 32'({m_idx[2:0], cur_key[m_idx*2 +: 2]}));
        rd_idx++;
        @(posedge clk); #1;
        chk("read_pulse", 32'(o_sdram_read), 32'(0));
        repeat (lat_l - 1) begin @(posedge clk); #1; end
        if (m_idx != hold_frag && m_idx < 5) begin
          i_sdram_readdata = mem[m_idx];
          i_sdram_readvalid = 1'b1;
          @(posedge clk); #1;
          i_sdram_readvalid = 1'b0;
          i_sdram_readdata = '0;
        end
      end
    end
  end

  task automatic start(input logic [4:0][20:0] segs, input logic [9:0] k, input int l, input int h);
    mem = segs; cur_key = k; lat_l = l; hold_frag = h; rd_idx = 0;
    @(negedge clk);
    i_search = 1'b1;
    i_search_key = k;
    @(posedge clk); #1;
    i_search = 1'b0;
  endtask

  task automatic run(input vec_t v, input int n);
    int cyc;
    bit seen;
    start(v.segs, v.key, v.l, v.hold);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      seen = o_search_done;
    end
    chk($sformatf("v%0d_latency", n), 32'(cyc), 32'(v.lat));
    chk($sformatf("v%0d_match", n), 32'(o_match), 32'(v.m));
    if (v.m) begin
      chk($sformatf("v%0d_id", n), 32'(o_match_id), 32'(v.id));
      chk($sformatf("v%0d_prio", n), 32'(o_match_priority), 32'(v.pr));
    end
    chk($sformatf("v%0d_collision", n), 32'(o_collision), 32'(v.c));
    chk($sformatf("v%0d_timeout", n), 32'(o_timeout), 32'(v.t));
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_idle", n), 32'({o_search_done, o_busy}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, dn, first_at;
    reset = 1'b0;
    i_search = 1'b0;
    i_search_key = '0;
    lat_l = 2; hold_frag = 7; rd_idx = 0; cur_key = '0; mem = '0;

    vt[0] = mk(10'h2A7, 2, 7, 25, 0, 0, 0, 0, 0);
    vt[1] = mk(10'h2A7, 2, 7, 25, 1, 2, 1, 0, 0);
    vt[1].segs[2] = seg(SINGLE, 2'd2, 5'd0, 10'h2A7, 2'd1);
    vt[2] = mk(10'h2A7, 2, 7, 25, 1, 3, 3, 1, 0);
    vt[2].segs[1] = seg(SINGLE, 2'd1, 5'd0, 10'h2A7, 2'd2);
    vt[2].segs[3] = seg(COLLIDED, 2'd3, 5'd0, 10'h2A7, 2'd3);
    vt[3] = mk(10'h000, 2, 7, 25, 1, 1, 2, 0, 0);
    vt[3].segs[0] = seg(SINGLE, 2'd1, 5'b11111, 10'h3FF, 2'd2);
    vt[4] = mk(10'h000, 2, 7, 25, 0, 0, 0, 0, 0);
    vt[4].segs[0] = seg(SINGLE, 2'd1, 5'b00000, 10'h3FF, 2'd2);
    vt[5] = mk(10'h2A7, 2, 7, 25, 1, 1, 2, 0, 0);
    vt[5].segs[1] = seg(SINGLE, 2'd1, 5'd0, 10'h2A7, 2'd2);
    vt[5].segs[4] = seg(SINGLE, 2'd3, 5'd0, 10'h2A7, 2'd2);
    vt[6] = mk(10'h3F0, 2, 7, 25, 1, 3, 0, 0, 0);
    vt[6].segs[0] = seg(SINGLE, 2'd3, 5'b00011, 10'h3FF, 2'd0);
    vt[7] = mk(10'h3F0, 2, 7, 25, 0, 0, 0, 0, 0);
    vt[7].segs[0] = seg(SINGLE, 2'd3, 5'b00001, 10'h3FF, 2'd0);
    vt[8] = mk(10'h2A7, 2, 7, 25, 0, 0, 0, 0, 0);
    vt[8].segs[2] = seg(2'b10, 2'd1, 5'd0, 10'h2A7, 2'd3);
    vt[9] = mk(10'h2A7, 2, 7, 25, 0, 0, 0, 1, 0);
    vt[9].segs[0] = seg(COLLIDED, 2'd1, 5'd0, 10'h155, 2'd3);
    vt[10] = mk(10'h2A7, 2, 7, 25, 1, 0, 3, 0, 0);
    vt[10].segs[0] = seg(SINGLE, 2'd0, 5'd0, 10'h2A7, 2'd3);
    vt[10].segs[4] = seg(SINGLE, 2'd2, 5'd0, 10'h2A7, 2'd1);
    vt[11] = mk(10'h2A7, 1, 7, 20, 1, 2, 1, 0, 0);
    vt[11].segs = vt[1].segs;
    vt[12] = mk(10'h2A7, 2, 1, 21, 0, 0, 0, 0, 1);
    vt[12].segs[0] = seg(SINGLE, 2'd1, 5'd0, 10'h2A7, 2'd2);
    vt[13] = vt[1];

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'({o_busy, o_sdram_read, o_sdram_addr, o_search_done, o_match, o_match_id,
                            o_match_priority, o_collision, o_timeout}), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run(vt[i], i);

    // Reset in the WAIT of fragment 3 aborts the search with nothing published
    start(vt[1].segs, 10'h2A7, 2, 7);
    cyc = 0;
    while (!(o_sdram_read && o_sdram_addr[4:2] == 3'd3) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_frag3", 32'(cyc < 100), 32'(1));
    chk("rst_busy_before", 32'({o_busy, o_match}), 32'(3));
    reset = 1'b0;
    #1;
    chk("rst_outputs", 32'({o_busy, o_sdram_read, o_sdram_addr, o_search_done, o_match, o_match_id,
                            o_match_priority, o_collision, o_timeout}), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      dn += int'(o_search_done);
    end
    chk("rst_no_done", 32'(dn), 32'(0));
    run(vt[1], 100);

    // Requests while busy and in the DONE cycle are dropped
    start(vt[0].segs, 10'h2A7, 2, 7);
    cyc = 0; dn = 0; first_at = 0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) chk("hold_match_midsearch", 32'({o_match, o_match_id, o_match_priority}), 32'(5'b1_10_01));
      if (o_search_done) begin
        dn++;
        first_at = cyc;
        i_search = 1'b1;
        i_search_key = 10'h3FF;
      end else begin
        i_search = cyc == 5;
        i_search_key = 10'h3FF;
      end
    end
    chk("busy_one_done", 32'(dn), 32'(1));
    chk("busy_done_cycle", 32'(first_at), 32'(25));
    chk("busy_final", 32'({o_busy, o_match}), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
